// File: rtl/gain_ramp.sv
// gain_ramp: fine multiplicative gain on NUM_CH packed channels per frame,
// with a per-frame bounded gain ramp, output saturation and sticky clip flags.
// A single multiplier is shared across channels, one channel per cycle.
//
// Ports:
//   bck          bit clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   target_gain  requested gain, Q2.(GAIN_WIDTH-2), sampled on accepted sync_in
//   mute         forces the effective target to 0 (ramped)
//   sync_in      one-cycle frame strobe, data_in valid in the same cycle
//   data_in      packed input samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   sync_out     one-cycle strobe, data_out valid from this cycle
//   data_out     packed output samples, held until the next sync_out
//   clip         per-channel sticky saturation flags
//   clip_clr     clears all clip flags (a coincident new saturation wins)
//   overrun      sticky, set when a frame arrives while busy; cleared by rst
//   ramping      high while the current gain differs from the live target
//
// state | meaning
// IDLE  | waiting for sync_in; the accepted frame steps cur_gain
// MUL   | one channel multiplied and saturated per cycle, ch_q selects it
// DONE  | results loaded into data_out, sync_out high, back to IDLE next
module gain_ramp #(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    NUM_CH     = 2,
  parameter int                    GAIN_WIDTH = 16,
  parameter logic [GAIN_WIDTH-1:0] RAMP_STEP  = 16'h0400
) (
  input  logic                         bck,
  input  logic                         rst,
  input  logic [GAIN_WIDTH-1:0]        target_gain,
  input  logic                         mute,
  input  logic                         sync_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic                         sync_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            clip,
  input  logic                         clip_clr,
  output logic                         overrun,
  output logic                         ramping
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FW = NUM_CH * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic [GAIN_WIDTH-1:0]   cur_gain_q, cur_gain_d;
  logic [FW-1:0]           din_q, din_d;
  logic [FW-1:0]           res_q, res_d;
  logic [FW-1:0]           data_out_q, data_out_d;
  logic                    sync_out_q, sync_out_d;
  logic [NUM_CH-1:0]       clip_q, clip_d;
  logic                    overrun_q, overrun_d;

  logic [GAIN_WIDTH-1:0]   tgt;
  logic [GAIN_WIDTH-1:0]   gain_next;
  logic [DATA_WIDTH-1:0]   sample;
  logic signed [PW-1:0]    samp_ext, gain_ext, prod, shifted;
  logic                    ovf_pos, ovf_neg;
  logic [DATA_WIDTH-1:0]   sat;

  assign tgt = mute ? '0 : target_gain;

  // Compare the distance to the target against the step first, so the
  // add/subtract can never cross the target and never wrap.
  always_comb begin
    gain_next = cur_gain_q;
    if (cur_gain_q < tgt) begin
      gain_next = ((tgt - cur_gain_q) > RAMP_STEP) ? cur_gain_q + RAMP_STEP : tgt;
    end else if (cur_gain_q > tgt) begin
      gain_next = ((cur_gain_q - tgt) > RAMP_STEP) ? cur_gain_q - RAMP_STEP : tgt;
    end
  end

  // Shared multiplier: both operands extended to full product width, the
  // gain as a non-negative value.
  assign sample   = din_q[ch_q*DATA_WIDTH +: DATA_WIDTH];
  assign samp_ext = {{(PW-DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
  assign gain_ext = {{(PW-GAIN_WIDTH){1'b0}}, cur_gain_q};
  assign prod     = samp_ext * gain_ext;
  assign shifted  = prod >>> (GAIN_WIDTH - 2);

  // The result fits only if every bit above the output sign bit matches it.
  assign ovf_pos = !shifted[PW-1] && (|shifted[PW-2:DATA_WIDTH-1]);
  assign ovf_neg = shifted[PW-1] && !(&shifted[PW-2:DATA_WIDTH-1]);
  assign sat     = ovf_pos ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                   ovf_neg ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                   shifted[DATA_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    cur_gain_d = cur_gain_q;
    din_d      = din_q;
    res_d      = res_q;
    data_out_d = data_out_q;
    sync_out_d = 1'b0;
    clip_d     = clip_q;
    overrun_d  = overrun_q;
    if (clip_clr) clip_d = '0;
    case (state_q)
      IDLE: begin
        if (sync_in) begin
          din_d      = data_in;
          cur_gain_d = gain_next;
          ch_d       = '0;
          state_d    = MUL;
        end
      end
      MUL: begin
        if (sync_in) overrun_d = 1'b1;
        res_d[ch_q*DATA_WIDTH +: DATA_WIDTH] = sat;
        if (ovf_pos || ovf_neg) clip_d[ch_q] = 1'b1;
        if (ch_q == CW'(NUM_CH - 1)) begin
          // Outputs are registered on entry to DONE so sync_out and the new
          // data_out appear together during the DONE cycle.
          data_out_d = res_d;
          sync_out_d = 1'b1;
          state_d    = DONE;
        end else begin
          ch_d = ch_q + CW'(1);
        end
      end
      DONE: begin
        if (sync_in) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bck) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      cur_gain_q <= '0;
      din_q      <= '0;
      res_q      <= '0;
      data_out_q <= '0;
      sync_out_q <= 1'b0;
      clip_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cur_gain_q <= cur_gain_d;
      din_q      <= din_d;
      res_q      <= res_d;
      data_out_q <= data_out_d;
      sync_out_q <= sync_out_d;
      clip_q     <= clip_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sync_out = sync_out_q;
  assign data_out = data_out_q;
  assign clip     = clip_q;
  assign overrun  = overrun_q;
  assign ramping  = (cur_gain_q != tgt);

endmodule

// File: tb/tb_gain_ramp.sv
module tb_gain_ramp;

  logic        bck = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] target_gain = '0;
  logic        mute = 1'b0;
  logic        sync_in = 1'b0;
  logic [47:0] data_in = '0;
  logic        clip_clr = 1'b0;
  logic        sync_out;
  logic [47:0] data_out;
  logic [1:0]  clip;
  logic        overrun;
  logic        ramping;

  gain_ramp #(
    .DATA_WIDTH(24),
    .NUM_CH(2),
    .GAIN_WIDTH(16),
    .RAMP_STEP(16'h0400)
  ) dut (
    .bck(bck),
    .rst(rst),
    .target_gain(target_gain),
    .mute(mute),
    .sync_in(sync_in),
    .data_in(data_in),
    .sync_out(sync_out),
    .data_out(data_out),
    .clip(clip),
    .clip_clr(clip_clr),
    .overrun(overrun),
    .ramping(ramping)
  );

  always #5 bck = ~bck;

  int cyc = 0;
  always @(posedge bck) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [23:0] el;
    logic [23:0] er;
    logic [1:0]  ec;
    int          t;
  } sb_t;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        clr;
    logic [23:0] el;
    logic [23:0] er;
    logic [1:0]  ec;
  } vec_t;

  sb_t         exp_q[$];
  sb_t         me;
  vec_t        vec[7];
  logic [47:0] held = '0;
  logic        rst_pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on each sync_out, otherwise checks
  // that data_out holds its last value.
  always @(negedge bck) begin
    if (rst) begin
      rst_pend = 1'b1;
    end else begin
      if (rst_pend) begin
        held     = '0;
        rst_pend = 1'b0;
      end
      if (sync_out) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_sync_out: got sync_out=1 expected none (cycle %0d)", cyc);
        end else begin
          me = exp_q.pop_front();
          chk("latency", 64'(cyc), 64'(me.t + 3));
          chk("data_l", 64'(data_out[23:0]), 64'(me.el));
          chk("data_r", 64'(data_out[47:24]), 64'(me.er));
          chk("clip", 64'(clip), 64'(me.ec));
        end
        held = data_out;
      end else begin
        chk("hold", 64'(data_out), 64'(held));
      end
    end
  end

  task automatic frame(input logic [15:0] g, input logic m, input logic [23:0] l,
                       input logic [23:0] r, input logic clr, input logic [23:0] el,
                       input logic [23:0] er, input logic [1:0] ec, input logic exp_ramp);
    sb_t e;
    @(posedge bck); #1;
    target_gain = g;
    mute        = m;
    data_in     = {r, l};
    clip_clr    = clr;
    sync_in     = 1'b1;
    e.el = el; e.er = er; e.ec = ec; e.t = cyc;
    exp_q.push_back(e);
    @(posedge bck); #1;
    sync_in  = 1'b0;
    clip_clr = 1'b0;
    data_in  = ~data_in;
    repeat (5) @(posedge bck);
    #1;
    chk("ramping", 64'(ramping), 64'(exp_ramp));
  endtask

  initial begin
    sb_t e;
    //           l           r           clr   el          er          ec
    vec[0] = '{24'h500000, 24'hB00000, 1'b0, 24'h7FFFFF, 24'h800000, 2'b11};
    vec[1] = '{24'h500000, 24'hB00000, 1'b1, 24'h7FFFFF, 24'h800000, 2'b11};
    vec[2] = '{24'h001000, 24'hFFF000, 1'b1, 24'h002000, 24'hFFE000, 2'b00};
    vec[3] = '{24'h3FFFFF, 24'hC00000, 1'b0, 24'h7FFFFE, 24'h800000, 2'b00};
    vec[4] = '{24'h400000, 24'h000000, 1'b0, 24'h7FFFFF, 24'h000000, 2'b01};
    vec[5] = '{24'h000001, 24'hBFFFFF, 1'b0, 24'h000002, 24'h800000, 2'b11};
    vec[6] = '{24'h123456, 24'h000000, 1'b1, 24'h2468AC, 24'h000000, 2'b00};

    repeat (3) @(posedge bck);
    #1 target_gain = 16'h4000;
    @(posedge bck); #1;
    rst = 1'b0;
    chk("rst_data_out", 64'(data_out), 64'h0);
    chk("rst_sync_out", 64'(sync_out), 64'h0);
    chk("rst_clip", 64'(clip), 64'h0);
    chk("rst_overrun", 64'(overrun), 64'h0);
    chk("rst_ramping", 64'(ramping), 64'h1);

    // Ramp up from silence: output grows by 0x010000 per frame to 0x100000.
    for (int i = 1; i <= 20; i++) begin
      logic [23:0] ev;
      ev = 24'(((i < 16) ? i : 16) * 32'h10000);
      frame(16'h4000, 1'b0, 24'h100000, 24'h100000, 1'b0, ev, ev, 2'b00, i < 16);
    end

    // Settle at gain 2.0 on silent frames.
    for (int i = 1; i <= 16; i++)
      frame(16'h8000, 1'b0, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0, 2'b00, i < 16);

    // Saturation, clip stickiness and clip_clr against steady gain 2.0.
    for (int i = 0; i < 7; i++)
      frame(16'h8000, 1'b0, vec[i].l, vec[i].r, vec[i].clr, vec[i].el, vec[i].er,
            vec[i].ec, 1'b0);

    // Back down to unity.
    for (int i = 1; i <= 16; i++)
      frame(16'h4000, 1'b0, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0, 2'b00, i < 16);

    // Mute: gain falls 0x3C00, 0x3800, ... to 0; -1 floors to -1 while gain > 0.
    for (int i = 1; i <= 18; i++) begin
      int g;
      logic [23:0] el, er;
      g  = (i < 16) ? (32'h4000 - i * 32'h400) : 0;
      el = (g != 0) ? 24'hFFFFFF : 24'h0;
      er = 24'(g * 64);
      frame(16'h4000, 1'b1, 24'hFFFFFF, 24'h100000, 1'b0, el, er, 2'b00, i < 16);
    end

    // Overrun: second strobe one cycle later is dropped.
    chk("overrun_pre", 64'(overrun), 64'h0);
    @(posedge bck); #1;
    mute        = 1'b0;
    target_gain = 16'h4000;
    data_in     = {24'h100000, 24'h100000};
    sync_in     = 1'b1;
    e.el = 24'h010000; e.er = 24'h010000; e.ec = 2'b00; e.t = cyc;
    exp_q.push_back(e);
    @(posedge bck); #1;
    data_in = {24'h300000, 24'h300000};
    @(posedge bck); #1;
    sync_in = 1'b0;
    repeat (5) @(posedge bck);
    #1;
    chk("overrun_post", 64'(overrun), 64'h1);
    frame(16'h4000, 1'b0, 24'h100000, 24'h100000, 1'b0, 24'h020000, 24'h020000, 2'b00, 1'b1);

    // Reset one cycle after an accepted strobe: the frame vanishes.
    @(posedge bck); #1;
    data_in = {24'h100000, 24'h100000};
    sync_in = 1'b1;
    @(posedge bck); #1;
    sync_in = 1'b0;
    rst     = 1'b1;
    @(posedge bck); #1;
    rst = 1'b0;
    chk("midrst_data_out", 64'(data_out), 64'h0);
    chk("midrst_overrun", 64'(overrun), 64'h0);
    chk("midrst_sync_out", 64'(sync_out), 64'h0);
    chk("midrst_ramping", 64'(ramping), 64'h1);
    repeat (6) @(posedge bck);
    frame(16'h4000, 1'b0, 24'h100000, 24'h100000, 1'b0, 24'h010000, 24'h010000, 2'b00, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge bck);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_sync_out: got %0d outstanding frames expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gain_ramp.md
Name: gain_ramp

Overview:
- Parametrised successor to the shift-only gain stage in the PRE 1 audio path.
- Applies a fine multiplicative gain to NUM_CH channels per sample frame, with saturation and per-channel sticky clip flags.
- Gain changes are ramped by a bounded step per frame, so volume changes and mute are free of zipper noise and pops.
- Sits between ser_to_par and par_to_ser. Clocked on bck, with one shared multiplier time-multiplexed across channels.

Parameters:
- DATA_WIDTH, 24: signed two's-complement sample width.
- NUM_CH, 2: channel count. Channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; channel 0 is left.
- GAIN_WIDTH, 16: unsigned gain in Q2.(GAIN_WIDTH-2) format. Unity is 1<<(GAIN_WIDTH-2), e.g. 0x4000.
- RAMP_STEP, 16'h0400: maximum change of the current gain per frame. Must be nonzero.

Ports:
- bck, in, 1: bit clock; the only clock. All logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- target_gain, in, GAIN_WIDTH: requested gain, sampled at each accepted sync_in.
- mute, in, 1: forces the effective target to 0 (ramped, not instant).
- sync_in, in, 1: one-cycle frame strobe; data_in is valid in the same cycle.
- data_in, in, NUM_CH*DATA_WIDTH: packed input samples.
- sync_out, out, 1: one-cycle strobe; data_out is valid from this cycle.
- data_out, out, NUM_CH*DATA_WIDTH: packed output samples, held until the next sync_out.
- clip, out, NUM_CH: per-channel sticky saturation flag.
- clip_clr, in, 1: clears all clip bits.
- overrun, out, 1: sticky flag, set when a frame is dropped; cleared only by rst.
- ramping, out, 1: high while cur_gain != effective target.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - state = IDLE; cur_gain = 0, so power-up ramps up from silence.
  - data_out = 0, sync_out = 0, clip = 0, overrun = 0, channel index = 0.
  - Any in-flight frame is discarded and produces no sync_out.
- Effective target: tgt = mute ? 0 : target_gain.
- States:
  - IDLE: on sync_in, capture data_in and tgt, update cur_gain, set ch = 0, go to MUL.
  - MUL: process one channel per cycle. At ch = NUM_CH-1, go to DONE; otherwise ch++.
  - DONE: load all results into data_out in parallel, pulse sync_out for one cycle, return to IDLE.
- Gain update (once per accepted frame, applied to that same frame):
  - if cur_gain < tgt: cur_gain = min(cur_gain + RAMP_STEP, tgt)
  - if cur_gain > tgt: cur_gain = max(cur_gain - RAMP_STEP, tgt)
  - Arithmetic must not wrap at either end of the range.
- Multiply, per channel:
  - p = signed sample * {1'b0, cur_gain}, at full width DATA_WIDTH+GAIN_WIDTH+1.
  - r = p >>> (GAIN_WIDTH-2): arithmetic shift, truncating toward minus infinity, no rounding.
- Saturation:
  - r > 2^(DATA_WIDTH-1)-1 gives 0x7FFFFF (for DATA_WIDTH=24).
  - r < -2^(DATA_WIDTH-1) gives 0x800000.
  - On either saturation, clip[ch] is set in that MUL cycle.
- clip_clr clears clip. If it coincides with a new saturation on a channel, set wins for that channel.
- Latency: sync_in at cycle t gives sync_out at t+NUM_CH+1. data_out changes only in that cycle.
- Frame drop: sync_in while state != IDLE (MUL or DONE) is ignored and sets overrun. The in-flight frame completes unaffected.
- Cycle budget: the design requires NUM_CH+2 ≤ bck cycles per frame (64 in the PRE 1).
- ramping is combinational from cur_gain and the live tgt.
- No output is affected by target_gain or mute between frames, except ramping.

Test Plan:
All cases use DATA_WIDTH=24, NUM_CH=2, GAIN_WIDTH=16, RAMP_STEP=0x0400, frames every 64 cycles.
1. Ramp up:
   - Stimulus: rst, then target_gain=0x4000, both channels 0x100000.
   - Required: first output 0x010000 (gain 0x0400). Output increases by 0x010000 per frame. Frame 16 onward equals 0x100000. ramping falls after frame 16.
2. Saturation:
   - Stimulus: steady gain 0x8000, left 0x500000, right 0xB00000.
   - Required: outputs 0x7FFFFF and 0x800000; clip=2'b11.
   - Then pulse clip_clr together with another clipping frame: clip stays 2'b11. With clip_clr and a non-clipping frame: clip=0.
3. Latency:
   - Stimulus: sync_in at cycle t.
   - Required: sync_out high only at t+3; data_out stable from t+3 until the next sync_out.
4. Mute and truncation:
   - Stimulus: settled at 0x4000, assert mute.
   - Required: gain steps 0x3C00, 0x3800, …, reaching 0 on frame 16, after which outputs are 0. At gain 0x2000, input 0xFFFFFF (-1) gives 0xFFFFFF (floor).
5. Overrun:
   - Stimulus: sync_in at t and t+1.
   - Required: overrun=1; exactly one sync_out, at t+3, carrying frame-t data.
6. Reset mid-operation:
   - Stimulus: rst at t+1 after sync_in at t.
   - Required: no sync_out; data_out=0, cur_gain=0, state IDLE. The next frame processes normally with gain 0x0400.
